debug_halt_sequencer: RTL
=========================

Name: debug_halt_sequencer

Overview:
Per-hart debug-mode entry/exit sequencer between the Debug Module, the CSR file and the pipeline's PC/execute stages. Arbitrates the halt sources: NUM_TRIG trigger channels, ebreak, haltreq, resethaltreq and single-step. It waits out pipeline stalls, issues a one-cycle halt request, latches the cause, and runs a resume handshake with the Debug Module. A stall-timeout watchdog flags a hung pipeline.

Parameters:
NUM_TRIG, 4, number of hardware trigger channels (1..16)
STALL_TIMEOUT, 64, WAIT_STALL cycles before stall_timeout_o sets (>=2)
RESET_HALT_EN, 1, 1 = honour resethaltreq_i; 0 = ignore it

Ports:
clk_i  in  1  processor clock
rst_i  in  1  reset; asynchronous, active-high
stall_i  in  1  pipeline stalled
haltreq_i  in  1  DM halt request, level
resethaltreq_i  in  1  DM halt-on-reset request, sampled at first edge after reset release
resumereq_i  in  1  DM resume request, one-cycle pulse
step_i  in  1  dcsr.step
retire_i  in  1  one instruction retired this cycle
trig_match_i  in  NUM_TRIG  per-channel trigger match
trig_en_i  in  NUM_TRIG  per-channel action = enter debug
ebreak_i  in  1  ebreak in execute
ebreakm_i  in  1  dcsr.ebreakm
halted_i  in  1  pipeline is parked in the debug loop
halt_req_o  out  1  one-cycle halt request to PC unit
save_dpc_o  out  1  write dpc/dcsr.cause this cycle
cause_o  out  3  latched dcsr.cause
trig_hit_o  out  NUM_TRIG  one-hot channel that caused entry
halted_o  out  1  hart halted status to DM
resume_ack_o  out  1  one-cycle resume acknowledge
stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async) state: RUNNING. All outputs 0; cause, trig_hit, watchdog counter, rh_pending, debug_mode = 0.
- First clock edge after reset release: rh_pending <= resethaltreq_i & RESET_HALT_EN.
- Cause codes: 1 ebreak, 2 trigger, 3 haltreq, 4 step, 5 resethaltreq.
- Event priority in RUNNING/STEPPING:
  - trig_hit = |(trig_match_i & trig_en_i)
  - then ebreak_i & ebreakm_i
  - then rh_pending
  - then haltreq_i
  - then (STEPPING & retire_i) as step.
- States and transitions:
  - RUNNING/STEPPING, event seen: go to WAIT_STALL if stall_i, else ENTERING. Latch cause and trig_hit on the decision cycle. trig_hit = lowest matching enabled index, one-hot.
  - WAIT_STALL: watchdog counts each cycle; go to ENTERING when ~stall_i. At count == STALL_TIMEOUT-1, set stall_timeout_o and keep waiting. Counter clears on leaving WAIT_STALL.
  - ENTERING: go to HALTED when halted_i.
  - HALTED: halted_o = 1, debug_mode = 1.
    - resumereq_i: go to RESUMING.
    - ebreak_i: re-enter ENTERING with halt_req_o. No save_dpc_o; cause unchanged.
  - RESUMING: when ~halted_i, pulse resume_ack_o for 1 cycle and clear debug_mode, trig_hit_o, stall_timeout_o. Next state is STEPPING if step_i, else RUNNING.
- halt_req_o: 1 exactly in the cycle the FSM enters ENTERING (combinational on state_d). Never 2 cycles consecutively.
- save_dpc_o = halt_req_o & ~debug_mode.
- rh_pending clears when its cause is latched. haltreq_i is a level: it re-halts right after resume if still high.
- resumereq_i is ignored outside HALTED. haltreq_i while halted is ignored.
- Simultaneous events resolve by priority. All losing sources are dropped, except rh_pending, which stays pending.
- Stepping: a trigger or ebreak during the stepped instruction wins over step cause.
- halted_i falling in HALTED without resumereq_i: go to RUNNING, no resume_ack_o.
- rst_i mid-operation: immediate return to reset state. An in-flight halt_req_o is dropped.

Test Plan:
- Reset release with resethaltreq_i=1, stall_i=0 -> halt_req_o and save_dpc_o pulse in cycle 1. cause_o=5. halted_i=1 gives halted_o=1 one cycle later.
- trig_match_i=4'b1010, trig_en_i=4'b1110, ebreak_i=1, ebreakm_i=1 in the same cycle -> cause_o=2, trig_hit_o=4'b0010.
- haltreq_i with stall_i held 70 cycles, STALL_TIMEOUT=64 -> stall_timeout_o=1 from wait cycle 63. halt_req_o fires the cycle after stall_i falls.
- Halted, step_i=1, resumereq_i pulse, halted_i drops -> resume_ack_o 1 cycle. After the first retire_i: halt_req_o with cause_o=4 and save_dpc_o=1.
- In HALTED, ebreak_i=1 -> halt_req_o=1, save_dpc_o=0, cause_o unchanged.
- rst_i asserted while in WAIT_STALL -> all outputs 0 asynchronously, before the next clk_i edge.

Source files
------------

// File: rtl/debug_halt_sequencer.sv
// Per-hart debug entry/exit sequencer: arbitrates halt sources, waits out stalls,
// issues the halt request, latches dcsr.cause and runs the resume handshake.
module debug_halt_sequencer #(
  parameter int NUM_TRIG      = 4,
  parameter int STALL_TIMEOUT = 64,
  parameter int RESET_HALT_EN = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                haltreq_i,
  input  logic                resethaltreq_i,
  input  logic                resumereq_i,
  input  logic                step_i,
  input  logic                retire_i,
  input  logic [NUM_TRIG-1:0] trig_match_i,
  input  logic [NUM_TRIG-1:0] trig_en_i,
  input  logic                ebreak_i,
  input  logic                ebreakm_i,
  input  logic                halted_i,
  output logic                halt_req_o,
  output logic                save_dpc_o,
  output logic [2:0]          cause_o,
  output logic [NUM_TRIG-1:0] trig_hit_o,
  output logic                halted_o,
  output logic                resume_ack_o,
  output logic                stall_timeout_o
);

  localparam int             CW      = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STALL_TIMEOUT - 1);
  localparam logic           RH_EN   = (RESET_HALT_EN != 0);

  localparam logic [2:0] C_EBREAK = 3'd1;
  localparam logic [2:0] C_TRIG   = 3'd2;
  localparam logic [2:0] C_HALT   = 3'd3;
  localparam logic [2:0] C_STEP   = 3'd4;
  localparam logic [2:0] C_RHALT  = 3'd5;

  typedef enum logic [2:0] {
    S_RUNNING, S_STEPPING, S_WAIT_STALL, S_ENTERING, S_HALTED, S_RESUMING
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cause_q, cause_d;
  logic [NUM_TRIG-1:0]   trig_hit_q, trig_hit_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rh_pending_q, rh_pending_d;
  logic                  debug_mode_q, debug_mode_d;
  logic                  timeout_q, timeout_d;
  logic                  init_q, init_d;

  logic [NUM_TRIG-1:0]   trig_vec, trig_first;
  logic                  evt;
  logic [2:0]            evt_cause;
  logic                  resume_fire;

  // Halt-source arbitration; trigger channel picked is the lowest enabled match.
  always_comb begin
    trig_vec   = trig_match_i & trig_en_i;
    trig_first = '0;
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (trig_vec[i]) begin
        trig_first    = '0;
        trig_first[i] = 1'b1;
      end
    end
    evt       = 1'b1;
    evt_cause = 3'd0;
    if (|trig_vec)                              evt_cause = C_TRIG;
    else if (ebreak_i && ebreakm_i)             evt_cause = C_EBREAK;
    else if (rh_pending_q)                      evt_cause = C_RHALT;
    else if (haltreq_i)                         evt_cause = C_HALT;
    else if (state_q == S_STEPPING && retire_i) evt_cause = C_STEP;
    else                                        evt = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    trig_hit_d   = trig_hit_q;
    rh_pending_d = rh_pending_q;
    debug_mode_d = debug_mode_q;
    timeout_d    = timeout_q;
    init_d       = 1'b1;
    resume_fire  = 1'b0;
    cnt_d        = '0;

    if (!init_q) rh_pending_d = resethaltreq_i & RH_EN;

    case (state_q)
      S_RUNNING, S_STEPPING: begin
        if (evt) begin
          cause_d    = evt_cause;
          trig_hit_d = trig_first;
          if (evt_cause == C_RHALT) rh_pending_d = 1'b0;
          state_d    = stall_i ? S_WAIT_STALL : S_ENTERING;
        end
      end
      S_WAIT_STALL: if (!stall_i) state_d = S_ENTERING;
      S_ENTERING:   if (halted_i) state_d = S_HALTED;
      S_HALTED: begin
        if (resumereq_i)   state_d = S_RESUMING;
        else if (ebreak_i) state_d = S_ENTERING;
        else if (!halted_i) begin
          // Pipeline left the debug loop on its own: no handshake to run.
          state_d      = S_RUNNING;
          debug_mode_d = 1'b0;
        end
      end
      S_RESUMING: begin
        if (!halted_i) begin
          resume_fire  = 1'b1;
          debug_mode_d = 1'b0;
          trig_hit_d   = '0;
          timeout_d    = 1'b0;
          state_d      = step_i ? S_STEPPING : S_RUNNING;
        end
      end
      default: state_d = S_RUNNING;
    endcase

    if (state_d == S_HALTED) debug_mode_d = 1'b1;

    // Flag rises together with the counter reaching its last value.
    if (state_q == S_WAIT_STALL && state_d == S_WAIT_STALL) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_RUNNING;
      cause_q      <= '0;
      trig_hit_q   <= '0;
      cnt_q        <= '0;
      rh_pending_q <= 1'b0;
      debug_mode_q <= 1'b0;
      timeout_q    <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      trig_hit_q   <= trig_hit_d;
      cnt_q        <= cnt_d;
      rh_pending_q <= rh_pending_d;
      debug_mode_q <= debug_mode_d;
      timeout_q    <= timeout_d;
      init_q       <= init_d;
    end
  end

  // Combinational pulses are gated by reset so they drop as soon as rst_i rises.
  assign halt_req_o      = ~rst_i & (state_d == S_ENTERING) & (state_q != S_ENTERING);
  assign save_dpc_o      = halt_req_o & ~debug_mode_q;
  assign resume_ack_o    = ~rst_i & resume_fire;
  assign cause_o         = cause_q;
  assign trig_hit_o      = trig_hit_q;
  assign halted_o        = (state_q == S_HALTED);
  assign stall_timeout_o = timeout_q;

endmodule
